leiwand_rv32_mem_loader: RTL and testbench

Bus-initiator program loader: receives a length-prefixed byte stream (e.g. from a UART receiver), packs bytes little-endian into 32-bit words and writes them over the core's valid/ready memory bus into program memory starting at `MEM_BASE`. It holds the core in reset during the load and releases it once the image is complete. It is the hardware counterpart of the simulation-time image load: it is the writer that fills the memory the core later fetches from. It sits between the byte source and the memory bus, muxed ahead of the core's bus port while `cpu_reset` is high.

---
 rtl/leiwand_rv32_mem_loader_pkg.sv | 20 ++
 rtl/leiwand_rv32_mem_loader_if.sv | 25 ++
 rtl/leiwand_rv32_byte_packer.sv | 51 +++++
 rtl/leiwand_rv32_mem_loader.sv | 153 +++++++++++++++
 tb/tb_leiwand_rv32_mem_loader.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/leiwand_rv32_mem_loader_pkg.sv
// Shared constants for the rv32 program loader.
// LEIWAND_LOADER_CHECKSUM_EN adds the trailing checksum state.
package leiwand_rv32_mem_loader_pkg;

    localparam int MEM_WIDTH = 32;
    localparam int HDR_BYTES = 4;
    localparam logic [MEM_WIDTH-1:0] MEM_BASE_DEFAULT = 32'h2040_0000;

    typedef enum logic [2:0] {
        S_LEN   = 3'd0,
        S_DATA  = 3'd1,
        S_WRITE = 3'd2,
`ifdef LEIWAND_LOADER_CHECKSUM_EN
        S_CSUM  = 3'd3,
`endif
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_e;

endpackage

// File: rtl/leiwand_rv32_mem_loader_if.sv
// Byte-stream input and memory-bus write port of the loader.
// master = loader side, slave = byte source plus memory responder.
interface leiwand_rv32_mem_loader_if;
    import leiwand_rv32_mem_loader_pkg::*;

    logic                 rx_valid;
    logic [7:0]           rx_data;
    logic                 rx_ready;
    logic                 mem_valid;
    logic                 mem_ready;
    logic [MEM_WIDTH-1:0] mem_addr;
    logic [MEM_WIDTH-1:0] mem_wdata;
    logic [3:0]           mem_wen;

    modport master (
        input  rx_valid, rx_data, mem_ready,
        output rx_ready, mem_valid, mem_addr, mem_wdata, mem_wen
    );

    modport slave (
        output rx_valid, rx_data, mem_ready,
        input  rx_ready, mem_valid, mem_addr, mem_wdata, mem_wen
    );

endinterface

// File: rtl/leiwand_rv32_byte_packer.sv
// Packs bytes little-endian into a word; the byte-enable mask
// records filled lanes, so a partial word gets (1<<n)-1.
module leiwand_rv32_byte_packer
    import leiwand_rv32_mem_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_i,
    input  logic [7:0]           byte_i,
    input  logic                 clear_i,
    output logic [1:0]           lane_o,
    output logic [MEM_WIDTH-1:0] word_o,
    output logic [3:0]           wen_o
);

    logic [1:0]           lane_q, lane_d;
    logic [MEM_WIDTH-1:0] data_q, data_d;
    logic [3:0]           wen_q, wen_d;

    always_comb begin
        lane_d = lane_q;
        data_d = data_q;
        wen_d  = wen_q;
        if (clear_i) begin
            lane_d = '0;
            data_d = '0;
            wen_d  = '0;
        end else if (push_i) begin
            data_d[{lane_q, 3'b000} +: 8] = byte_i;
            wen_d[lane_q] = 1'b1;
            lane_d = lane_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_q <= '0;
            data_q <= '0;
            wen_q  <= '0;
        end else begin
            lane_q <= lane_d;
            data_q <= data_d;
            wen_q  <= wen_d;
        end
    end

    assign lane_o = lane_q;
    assign word_o = data_q;
    assign wen_o  = wen_q;

endmodule

// File: rtl/leiwand_rv32_mem_loader.sv
// Length-prefixed byte stream to memory-bus writes; holds the core
// in reset until loaded. LEIWAND_LOADER_CHECKSUM_EN adds a sum byte.
module leiwand_rv32_mem_loader
    import leiwand_rv32_mem_loader_pkg::*;
#(
    parameter logic [MEM_WIDTH-1:0] MEM_BASE   = MEM_BASE_DEFAULT,
    parameter int                   LOAD_WORDS = 4096
) (
    input  logic                      clk,
    input  logic                      reset,
    leiwand_rv32_mem_loader_if.master bus,
    output logic                      cpu_reset,
    output logic                      done,
    output logic                      error
);

    localparam logic [32:0] CAP = 33'(LOAD_WORDS) << 2;
    localparam logic [1:0]  HDR_LAST = 2'(HDR_BYTES - 1);

`ifdef LEIWAND_LOADER_CHECKSUM_EN
    localparam state_e S_FINISH = S_CSUM;
    logic [7:0] csum_q, csum_d;
`else
    localparam state_e S_FINISH = S_DONE;
`endif

    state_e               state_q, state_d;
    logic                 run_q;
    logic [1:0]           hdr_q, hdr_d;
    logic [23:0]          len_q, len_d;
    logic [31:0]          rem_q, rem_d;
    logic [MEM_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]          len_full;
    logic                 rx_ready;
    logic                 rx_fire;
    logic                 push;
    logic                 clear;
    logic [1:0]           pk_lane;
    logic [MEM_WIDTH-1:0] pk_word;
    logic [3:0]           pk_wen;

    assign len_full = {bus.rx_data, len_q};
    assign rx_fire  = rx_ready && bus.rx_valid;

    always_comb begin
        state_d  = state_q;
        hdr_d    = hdr_q;
        len_d    = len_q;
        rem_d    = rem_q;
        addr_d   = addr_q;
        rx_ready = 1'b0;
        push     = 1'b0;
        clear    = 1'b0;
`ifdef LEIWAND_LOADER_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        unique case (state_q)
            S_LEN: begin
                // run_q keeps rx_ready low until reset has released
                rx_ready = run_q;
                if (rx_fire) begin
                    hdr_d = hdr_q + 2'd1;
                    unique case (hdr_q)
                        2'd0: len_d[7:0]   = bus.rx_data;
                        2'd1: len_d[15:8]  = bus.rx_data;
                        2'd2: len_d[23:16] = bus.rx_data;
                        default: begin
                            rem_d = len_full;
                            if (len_full == 32'd0)
                                state_d = S_FINISH;
                            else if ({1'b0, len_full} > CAP)
                                state_d = S_ERR;
                            else
                                state_d = S_DATA;
                        end
                    endcase
                end
            end
            S_DATA: begin
                rx_ready = 1'b1;
                if (rx_fire) begin
                    push  = 1'b1;
                    rem_d = rem_q - 32'd1;
`ifdef LEIWAND_LOADER_CHECKSUM_EN
                    csum_d = csum_q + bus.rx_data;
`endif
                    if (pk_lane == 2'd3 || rem_q == 32'd1)
                        state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (bus.mem_ready) begin
                    clear   = 1'b1;
                    addr_d  = addr_q + MEM_WIDTH'(4);
                    state_d = (rem_q == 32'd0) ? S_FINISH : S_DATA;
                end
            end
`ifdef LEIWAND_LOADER_CHECKSUM_EN
            S_CSUM: begin
                rx_ready = 1'b1;
                if (rx_fire)
                    state_d = (bus.rx_data == csum_q) ? S_DONE : S_ERR;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_LEN;
            run_q   <= 1'b0;
            hdr_q   <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            addr_q  <= MEM_BASE;
`ifdef LEIWAND_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            hdr_q   <= hdr_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
`ifdef LEIWAND_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    leiwand_rv32_byte_packer u_packer (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .byte_i  (bus.rx_data),
        .clear_i (clear),
        .lane_o  (pk_lane),
        .word_o  (pk_word),
        .wen_o   (pk_wen)
    );

    assign bus.rx_ready  = rx_ready;
    assign bus.mem_valid = (state_q == S_WRITE);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = pk_word;
    assign bus.mem_wen   = pk_wen;
    assign done          = (state_q == S_DONE);
    assign error         = (state_q == S_ERR);
    assign cpu_reset     = (state_q != S_DONE);

endmodule

// File: tb/tb_leiwand_rv32_mem_loader.sv
// Scoreboard bench for the program loader: frames push expected
// writes, a negedge responder/monitor pops and compares them.
module tb_leiwand_rv32_mem_loader;

    localparam logic [31:0] B = 32'h2040_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  wen;
    } wr_t;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic cpu_reset, done, error;

    leiwand_rv32_mem_loader_if bus();

    leiwand_rv32_mem_loader dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    wr_t         exp_q[$];
    wr_t         e;
    int          checks = 0;
    int          errors = 0;
    int          delay = 0;
    int          wcnt = 0;
    bit          in_write = 0;
    logic [31:0] h_addr, h_data;
    logic [3:0]  h_wen;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // responder and monitor: mem_ready set here is sampled next posedge
    always @(negedge clk) begin
        if (!bus.mem_valid) begin
            bus.mem_ready = 1'b0;
            wcnt = 0;
            in_write = 0;
        end else begin
            if (!in_write) begin
                in_write = 1;
                h_addr = bus.mem_addr;
                h_data = bus.mem_wdata;
                h_wen  = bus.mem_wen;
            end else begin
                chk("addr_stable", bus.mem_addr, h_addr);
                chk("wdata_stable", bus.mem_wdata, h_data);
                chk("wen_stable", 32'(bus.mem_wen), 32'(h_wen));
            end
            chk("rx_ready_in_write", 32'(bus.rx_ready), 32'd0);
            chk("cpu_reset_in_write", 32'(cpu_reset), 32'd1);
            if (wcnt >= delay) begin
                bus.mem_ready = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %h want none",
                             bus.mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("mem_addr", bus.mem_addr, e.addr);
                    chk("mem_wdata", bus.mem_wdata, e.data);
                    chk("mem_wen", 32'(bus.mem_wen), 32'(e.wen));
                end
            end else begin
                bus.mem_ready = 1'b0;
            end
            wcnt++;
        end
    end

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] w);
        wr_t x;
        x.addr = a;
        x.data = d;
        x.wen  = w;
        exp_q.push_back(x);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        forever begin
            #1;
            if (bus.rx_ready) break;
            t++;
            if (t > 500) begin
                checks++;
                errors++;
                $display("FAIL rx_timeout: got rx_ready 0 want 1");
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
    endtask

    task automatic send_frame(input bq_t f, input bit add_csum);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < f.size(); i++) begin
            send_byte(f[i]);
            if (i >= 4) s = s + f[i];
        end
`ifdef LEIWAND_LOADER_CHECKSUM_EN
        if (add_csum) send_byte(s);
`else
        if (add_csum) s = 8'h00;
`endif
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (!done && !error && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            checks++;
            errors++;
            $display("FAIL end_timeout: got done 0 error 0 want either");
        end
    endtask

    task automatic check_ok(input string tag);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_err(input string tag);
        chk({tag, "_error"}, 32'(error), 32'd1);
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.rx_valid = 1'b0;
        #1;
        chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
        chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, B);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_mem_wen", 32'(bus.mem_wen), 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bq_t f;
        int t;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.mem_ready = 1'b0;

        do_reset();
        expect_wr(B, 32'h2000_3713, 4'b1111);
        expect_wr(B + 4, 32'hDEAD_BEEF, 4'b1111);
        f = '{8'h08, 8'h00, 8'h00, 8'h00,
              8'h13, 8'h37, 8'h00, 8'h20,
              8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_frame(f, 1'b1);
        wait_end();
        check_ok("len8");
        @(negedge clk);
        bus.rx_valid = 1'b1;
        #1;
        chk("after_done_rx_ready", 32'(bus.rx_ready), 32'd0);
        bus.rx_valid = 1'b0;

        do_reset();
        delay = 3;
        expect_wr(B, 32'h4433_2211, 4'b1111);
        expect_wr(B + 4, 32'h0000_6655, 4'b0011);
        f = '{8'h06, 8'h00, 8'h00, 8'h00,
              8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_frame(f, 1'b1);
        wait_end();
        check_ok("len6");

        do_reset();
        delay = 0;
        expect_wr(B, 32'h000C_0B0A, 4'b0111);
        f = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h0B, 8'h0C};
        send_frame(f, 1'b1);
        wait_end();
        check_ok("len3");

        do_reset();
        f = '{8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(f, 1'b1);
        wait_end();
        check_ok("len0");

        do_reset();
        f = '{8'h01, 8'h40, 8'h00, 8'h00};
        send_frame(f, 1'b0);
        wait_end();
        repeat (3) @(negedge clk);
        check_err("oversize");

`ifdef LEIWAND_LOADER_CHECKSUM_EN
        do_reset();
        expect_wr(B, 32'h0000_0201, 4'b0011);
        f = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03};
        send_frame(f, 1'b0);
        wait_end();
        check_ok("csum_good");

        do_reset();
        expect_wr(B, 32'h0000_0201, 4'b0011);
        f = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h04};
        send_frame(f, 1'b0);
        wait_end();
        check_err("csum_bad");
        chk("csum_bad_pending", 32'(exp_q.size()), 32'd0);
`endif

        do_reset();
        delay = 20;
        f = '{8'h04, 8'h00, 8'h00, 8'h00,
              8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_frame(f, 1'b0);
        t = 0;
        while (!bus.mem_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("midwrite_valid_seen", 32'(bus.mem_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("midwrite_async_drop", 32'(bus.mem_valid), 32'd0);
        chk("midwrite_addr", bus.mem_addr, B);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        delay = 0;
        expect_wr(B, 32'h0403_0201, 4'b1111);
        f = '{8'h04, 8'h00, 8'h00, 8'h00,
              8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(f, 1'b1);
        wait_end();
        check_ok("reload");

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
